mini_alu_seq: RTL

Parametrised successor to the lab mini-ALU sequencer: fetches 28-bit instructions from the external instruction ROM, reads operands from the external dual-read-port data RAM, executes, and writes results back. It adds configurable data width, a nested CALL/RET return-address stack, a multi-cycle signed shift-add multiplier with stall, and a full LCD handshake wait. It sits between `ROM`/`RAM_DUAL_READ_PORT` and the LCD controller and LED bank at top level.

---
 rtl/mini_alu_pkg.sv | 32 +++
 rtl/mini_alu_ret_stack.sv | 41 ++++
 rtl/mini_alu_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini-ALU sequencer: opcodes, FSM states and instruction field layout.
package mini_alu_pkg;

  localparam int INSTR_W  = 28;
  localparam int OP_LSB   = 24;
  localparam int OP_W     = 4;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_LSB = 0;
  localparam int FIELD_W  = 8;

  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W-1:0] OP_STO  = 4'd3;
  localparam logic [OP_W-1:0] OP_BLE  = 4'd4;
  localparam logic [OP_W-1:0] OP_JMP  = 4'd5;
  localparam logic [OP_W-1:0] OP_LED  = 4'd6;
  localparam logic [OP_W-1:0] OP_CALL = 4'd7;
  localparam logic [OP_W-1:0] OP_RET  = 4'd8;
  localparam logic [OP_W-1:0] OP_SMUL = 4'd9;
  localparam logic [OP_W-1:0] OP_LCD  = 4'd10;
  localparam logic [OP_W-1:0] OP_SLH  = 4'd11;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MUL,
    ST_LCD_WAIT
  } state_e;

endpackage

// File: rtl/mini_alu_ret_stack.sv
// Return-address LIFO for CALL/RET: DEPTH entries of W bits with full/empty flags.
module mini_alu_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] sp_q, sp_d, sp_m1;
  logic [W-1:0]     mem_q [DEPTH];

  assign sp_m1   = sp_q - PTR_W'(1);
  assign full_o  = (sp_q == PTR_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[sp_m1[PTR_W-2:0]];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)      sp_d = sp_q + PTR_W'(1);
    else if (pop_i && !empty_o) sp_d = sp_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: entries need no reset; the pointer alone decides which ones are valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[sp_q[PTR_W-2:0]] <= push_data_i;
  end

endmodule

// File: rtl/mini_alu_seq.sv
// Mini-ALU sequencer: ROM fetch, dual-read RAM execute/write-back, CALL/RET stack, LED and LCD handshake.
// Define MINI_ALU_SMUL_EN to compile in the multi-cycle signed shift-add multiplier (SMUL).
module mini_alu_seq
  import mini_alu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IP_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IP_W-1:0]    oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [7:0]         oReadAddr0,
  output logic [7:0]         oReadAddr1,
  input  logic [DATA_W-1:0]  iReadData0,
  input  logic [DATA_W-1:0]  iReadData1,
  output logic               oWriteEnable,
  output logic [7:0]         oWriteAddr,
  output logic [DATA_W-1:0]  oWriteData,
  output logic [7:0]         oLed,
  output logic [3:0]         oLCD_data,
  output logic               oLCD_writeEN,
  input  logic               iLCD_response,
  output logic               oStackFault
);
  state_e             state_q, state_d;
  logic [IP_W-1:0]    ip_q, ip_d, ip_inc, dest_ip, ras_top;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [7:0]         led_q, led_d, waddr;
  logic [3:0]         lcd_data_q, lcd_data_d;
  logic               lcd_en_q, lcd_en_d, fault_q, fault_d;
  logic               push, pop, ras_full, ras_empty, we;
  logic [OP_W-1:0]    op;
  logic [FIELD_W-1:0] dest;
  logic [DATA_W-1:0]  s0, s1, wdata, sto_val;

  assign op      = ir_q[OP_LSB +: OP_W];
  assign dest    = ir_q[DEST_LSB +: FIELD_W];
  assign s0      = iReadData0;
  assign s1      = iReadData1;
  assign ip_inc  = ip_q + IP_W'(1);
  assign dest_ip = IP_W'(dest);
  // {src1,src0} is a signed 16-bit immediate, sign-extended or truncated to the data width.
  assign sto_val = DATA_W'($signed(ir_q[SRC0_LSB +: 2*FIELD_W]));

`ifdef MINI_ALU_SMUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Low DATA_W bits of a two's-complement product match the unsigned product.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_FETCH;
      ip_q       <= '0;
      ir_q       <= '0;
      led_q      <= '0;
      lcd_data_q <= '0;
      lcd_en_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      ir_q       <= ir_d;
      led_q      <= led_d;
      lcd_data_q <= lcd_data_d;
      lcd_en_q   <= lcd_en_d;
      fault_q    <= fault_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    ir_d       = ir_q;
    led_d      = led_q;
    lcd_data_d = lcd_data_q;
    lcd_en_d   = lcd_en_q;
    fault_d    = fault_q;
    push       = 1'b0;
    pop        = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
`ifdef MINI_ALU_SMUL_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_FETCH: begin
        ir_d    = iInstruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ip_d    = ip_inc;
        state_d = ST_FETCH;
        case (op)
          OP_ADD:  begin we = 1'b1; waddr = dest; wdata = s1 + s0; end
          OP_SUB:  begin we = 1'b1; waddr = dest; wdata = s1 - s0; end
          OP_STO:  begin we = 1'b1; waddr = dest; wdata = sto_val; end
          OP_BLE:  if ($signed(s1) <= $signed(s0)) ip_d = dest_ip;
          OP_JMP:  ip_d = dest_ip;
          OP_LED:  led_d = s1[7:0];
          OP_CALL: begin
            if (ras_full) fault_d = 1'b1;
            else begin push = 1'b1; ip_d = dest_ip; end
          end
          OP_RET: begin
            if (ras_empty) fault_d = 1'b1;
            else begin pop = 1'b1; ip_d = ras_top; end
          end
`ifdef MINI_ALU_SMUL_EN
          OP_SMUL: begin
            ip_d     = ip_q;
            state_d  = ST_MUL;
            mcand_d  = s0;
            mplier_d = s1;
            acc_d    = '0;
            cnt_d    = '0;
          end
`endif
          OP_LCD, OP_SLH: begin
            ip_d       = ip_q;
            state_d    = ST_LCD_WAIT;
            lcd_en_d   = 1'b1;
            lcd_data_d = (op == OP_LCD) ? s1[7:4] : s1[3:0];
          end
          default: ;
        endcase
      end
`ifdef MINI_ALU_SMUL_EN
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          we      = 1'b1;
          waddr   = dest;
          wdata   = acc_step;
          ip_d    = ip_inc;
          state_d = ST_FETCH;
        end
      end
`endif
      ST_LCD_WAIT: begin
        if (iLCD_response) begin
          lcd_en_d = 1'b0;
          ip_d     = ip_inc;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  mini_alu_ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (IP_W)
  ) u_ret_stack (
    .clk         (Clock),
    .rst_n       (Reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ip_inc),
    .top_o       (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  assign oIP          = ip_q;
  assign oReadAddr0   = ir_q[SRC0_LSB +: FIELD_W];
  assign oReadAddr1   = ir_q[SRC1_LSB +: FIELD_W];
  assign oWriteEnable = we;
  assign oWriteAddr   = waddr;
  assign oWriteData   = wdata;
  assign oLed         = led_q;
  assign oLCD_data    = lcd_data_q;
  assign oLCD_writeEN = lcd_en_q;
  assign oStackFault  = fault_q;

endmodule
